// File: rtl/decode_pkg.sv
// Shared types for the decode arbiter: letter alphabet, arbiter states and
// the 12-letter membership test used by the substitution decoder.
package decode_pkg;

    localparam int CHAR_W = 8;

    typedef enum logic [CHAR_W-1:0] {
        A_E = 8'h45, A_T = 8'h54, A_A = 8'h41, A_O = 8'h4F,
        A_I = 8'h49, A_N = 8'h4E, A_S = 8'h53, A_H = 8'h48,
        A_R = 8'h52, A_D = 8'h44, A_L = 8'h4C, A_U = 8'h55
    } alpha_t;

    typedef enum logic {IDLE, LOCK} arb_state_t;

    function automatic logic is_alpha(input logic [CHAR_W-1:0] c);
        return c inside {A_E, A_T, A_A, A_O, A_I, A_N, A_S, A_H, A_R, A_D, A_L, A_U};
    endfunction

endpackage

// File: rtl/decode_arbiter_if.sv
// Cipher-text ingress and plaintext egress streams of the decode arbiter.
// master = sources plus consumer, slave = the arbiter itself.
interface decode_arbiter_if
    import decode_pkg::*;
#(
    parameter int NREQ = 2
) ();
    localparam int SRC_W = $clog2(NREQ);

    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0][CHAR_W-1:0] req_char;
    logic [NREQ-1:0]             req_last;
    logic [NREQ-1:0]             req_ready;
    logic                        out_valid;
    logic [CHAR_W-1:0]           out_char;
    logic                        out_last;
    logic [SRC_W-1:0]            out_src;
    logic                        out_miss;
    logic                        out_ready;

    modport master (
        output req_valid, req_char, req_last, out_ready,
        input  req_ready, out_valid, out_char, out_last, out_src, out_miss
    );

    modport slave (
        input  req_valid, req_char, req_last, out_ready,
        output req_ready, out_valid, out_char, out_last, out_src, out_miss
    );
endinterface

// File: rtl/decode_arbiter_decoder.sv
// Combinational letter substitution over the 12-letter alphabet; any other
// character passes through unchanged and is flagged as a miss.
module decode_arbiter_decoder
    import decode_pkg::*;
(
    input  logic [CHAR_W-1:0] cipher_i,
    output logic [CHAR_W-1:0] plain_o,
    output logic              miss_o
);
    always_comb begin
        plain_o = cipher_i;
        miss_o  = !is_alpha(cipher_i);
        case (cipher_i)
            A_E:     plain_o = A_U;
            A_T:     plain_o = A_N;
            A_A:     plain_o = A_T;
            A_O:     plain_o = A_I;
            A_I:     plain_o = A_E;
            A_N:     plain_o = A_H;
            A_S:     plain_o = A_R;
            A_H:     plain_o = A_A;
            A_R:     plain_o = A_L;
            A_D:     plain_o = A_S;
            A_L:     plain_o = A_D;
            A_U:     plain_o = A_O;
            default: plain_o = cipher_i;
        endcase
    end
endmodule

// File: rtl/decode_arbiter.sv
// Round-robin message arbiter sharing one substitution decoder between NREQ
// sources. Optional DECODE_MISS_CNT_EN adds a saturating miss counter output.
module decode_arbiter
    import decode_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int MAXLEN = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    decode_arbiter_if.slave     bus,
    output logic                busy_o,
`ifdef DECODE_MISS_CNT_EN
    output logic [15:0]         miss_cnt_o,
`endif
    output logic                err_len_o
);
    localparam int SRC_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(MAXLEN + 1);

    arb_state_t        state_q, state_d;
    logic [SRC_W-1:0]  gnt_q, gnt_d, rr_q, rr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [CHAR_W-1:0] out_char_q, out_char_d;
    logic              out_last_q, out_last_d;
    logic [SRC_W-1:0]  out_src_q, out_src_d;
    logic              out_miss_q, out_miss_d;
    logic              err_len_q, err_len_d;

    logic              out_free, accept, cur_last, force_end, pick_found;
    logic [SRC_W-1:0]  pick_idx, cand;
    logic [CHAR_W-1:0] dec_plain;
    logic              dec_miss;

    assign out_free  = !out_valid_q || bus.out_ready;
    assign accept    = (state_q == LOCK) && bus.req_valid[gnt_q] && out_free;
    assign cur_last  = bus.req_last[gnt_q];
    assign force_end = (count_q == CNT_W'(MAXLEN - 1)) && !cur_last;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign bus.req_ready[gi] = (state_q == LOCK) && (gnt_q == SRC_W'(gi)) && out_free;
    end

    decode_arbiter_decoder u_decoder (
        .cipher_i (bus.req_char[gnt_q]),
        .plain_o  (dec_plain),
        .miss_o   (dec_miss)
    );

    // Scan from the farthest offset down so the nearest valid at/after rr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = SRC_W'((int'(rr_q) + k) % NREQ);
            if (bus.req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        out_char_d  = out_char_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        out_miss_d  = out_miss_q;
        err_len_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d   = pick_idx;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_char_d  = dec_plain;
                    out_miss_d  = dec_miss;
                    out_src_d   = gnt_q;
                    out_last_d  = cur_last || force_end;
                    err_len_d   = force_end;
                    if (cur_last || force_end) begin
                        state_d = IDLE;
                        count_d = '0;
                        rr_d    = (gnt_q == SRC_W'(NREQ - 1)) ? '0 : gnt_q + SRC_W'(1);
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rr_q        <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_char_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
            out_miss_q  <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_q        <= rr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
            out_miss_q  <= out_miss_d;
            err_len_q   <= err_len_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_char  = out_char_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_miss  = out_miss_q;
    assign busy_o        = (state_q == LOCK);
    assign err_len_o     = err_len_q;

`ifdef DECODE_MISS_CNT_EN
    logic [15:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (out_valid_q && bus.out_ready && out_miss_q && (miss_cnt_q != 16'hFFFF))
            miss_cnt_d = miss_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) miss_cnt_q <= '0;
        else       miss_cnt_q <= miss_cnt_d;
    end

    assign miss_cnt_o = miss_cnt_q;
`endif
endmodule

// File: tb/tb_decode_arbiter.sv
// Directed bench for decode_arbiter: sources are driven from per-requester
// queues, every output handshake is logged and compared with hand-decoded text.
module tb_decode_arbiter;
    localparam int NREQ   = 2;
    localparam int MAXLEN = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_arbiter_if #(.NREQ(NREQ)) bus ();
    logic busy, err_len;
`ifdef DECODE_MISS_CNT_EN
    logic [15:0] miss_cnt;
`endif

    decode_arbiter #(.NREQ(NREQ), .MAXLEN(MAXLEN)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .busy_o     (busy),
`ifdef DECODE_MISS_CNT_EN
        .miss_cnt_o (miss_cnt),
`endif
        .err_len_o  (err_len)
    );

    typedef struct {
        logic [7:0] ch;
        logic       last;
        logic [0:0] src;
        logic       miss;
        logic       err;
        int         cyc;
    } obs_t;

    obs_t       obs[$];
    int         acc_cyc[$];
    logic [7:0] sq_ch[NREQ][$];
    logic       sq_last[NREQ][$];
    int         cyc, err_cnt;
    int         tests_run, tests_failed;

    logic            s_valid, s_last, s_miss, s_busy, s_err;
    logic [7:0]      s_char;
    logic [0:0]      s_src;
    logic [NREQ-1:0] s_rr;

    // One clock: drive from queue fronts, sample at negedge, pop accepted chars.
    task automatic step(input logic rdy);
        logic [NREQ-1:0] hs;
        obs_t o;
        for (int r = 0; r < NREQ; r++) begin
            if (sq_ch[r].size() > 0) begin
                bus.req_valid[r] = 1'b1;
                bus.req_char[r]  = sq_ch[r][0];
                bus.req_last[r]  = sq_last[r][0];
            end else begin
                bus.req_valid[r] = 1'b0;
                bus.req_char[r]  = 8'h00;
                bus.req_last[r]  = 1'b0;
            end
        end
        bus.out_ready = rdy;
        @(negedge clk);
        cyc++;
        s_valid = bus.out_valid; s_char = bus.out_char; s_last = bus.out_last;
        s_src = bus.out_src; s_miss = bus.out_miss; s_busy = busy; s_err = err_len;
        s_rr = bus.req_ready;
        if (err_len) err_cnt++;
        hs = bus.req_valid & bus.req_ready;
        if (hs[0]) acc_cyc.push_back(cyc);
        if (bus.out_valid && bus.out_ready) begin
            o.ch = bus.out_char; o.last = bus.out_last; o.src = bus.out_src;
            o.miss = bus.out_miss; o.err = err_len; o.cyc = cyc;
            obs.push_back(o);
            $display("[TB] out cyc=%0d src=%0d char=%c last=%0b miss=%0b err=%0b",
                     cyc, o.src, o.ch, o.last, o.miss, o.err);
        end
        @(posedge clk);
        #1;
        for (int r = 0; r < NREQ; r++) begin
            if (hs[r]) begin
                void'(sq_ch[r].pop_front());
                void'(sq_last[r].pop_front());
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        for (int r = 0; r < NREQ; r++) begin
            sq_ch[r].delete();
            sq_last[r].delete();
        end
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        obs.delete();
        acc_cyc.delete();
        err_cnt = 0;
    endtask

    task automatic push_msg(input int r, input string s, input bit with_last);
        for (int i = 0; i < s.len(); i++) begin
            sq_ch[r].push_back(s[i]);
            sq_last[r].push_back(with_last && (i == s.len() - 1));
        end
    endtask

    task automatic wait_obs(input int n, input int budget);
        for (int k = 0; k < budget && obs.size() < n; k++) step(1'b1);
    endtask

    function automatic string obs_str(input int field);
        string s = "";
        foreach (obs[i]) begin
            case (field)
                0:       s = {s, $sformatf("%c", obs[i].ch)};
                1:       s = {s, $sformatf("%0b", obs[i].last)};
                2:       s = {s, $sformatf("%0d", obs[i].src)};
                3:       s = {s, $sformatf("%0b", obs[i].miss)};
                default: s = {s, $sformatf("%0b", obs[i].err)};
            endcase
        end
        return s;
    endfunction

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if ({s_valid, s_char, s_last, s_src, s_miss} !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_out got=%h want=000", {s_valid, s_char, s_last, s_src, s_miss});
        end
        tests_run++;
        if ({s_busy, s_err, s_rr} !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_ctrl got=%b want=0000", {s_busy, s_err, s_rr});
        end
    endtask

    task automatic test_hello();
        apply_reset();
        push_msg(0, "NIRRU", 1);
        wait_obs(5, 50);
        tests_run++;
        if (obs_str(0) != "HELLO") begin
            tests_failed++; $display("FAIL hello_chars got=%s want=HELLO", obs_str(0));
        end
        tests_run++;
        if (obs_str(1) != "00001" || obs_str(2) != "00000" || obs_str(3) != "00000") begin
            tests_failed++;
            $display("FAIL hello_flags got=%s/%s/%s want=00001/00000/00000", obs_str(1), obs_str(2), obs_str(3));
        end
        if (obs.size() == 5 && acc_cyc.size() > 0) begin
            tests_run++;
            if (obs[0].cyc !== acc_cyc[0] + 1) begin
                tests_failed++; $display("FAIL hello_latency got=%0d want=%0d", obs[0].cyc, acc_cyc[0] + 1);
            end
            tests_run++;
            if (obs[4].cyc - obs[0].cyc !== 4) begin
                tests_failed++; $display("FAIL hello_burst got=%0d want=4", obs[4].cyc - obs[0].cyc);
            end
        end
    endtask

    task automatic test_contention();
        apply_reset();
        push_msg(0, "AOSH", 1);
        push_msg(0, "N", 1);
        push_msg(1, "AOSH", 1);
        wait_obs(9, 80);
        tests_run++;
        if (obs_str(0) != "TIRATIRAH") begin
            tests_failed++; $display("FAIL rr_chars got=%s want=TIRATIRAH", obs_str(0));
        end
        tests_run++;
        if (obs_str(2) != "000011110") begin
            tests_failed++; $display("FAIL rr_src got=%s want=000011110", obs_str(2));
        end
        tests_run++;
        if (obs_str(1) != "000100011") begin
            tests_failed++; $display("FAIL rr_last got=%s want=000100011", obs_str(1));
        end
        step(1'b1);
        tests_run++;
        if (s_busy !== 1'b0) begin
            tests_failed++; $display("FAIL rr_idle_busy got=%b want=0", s_busy);
        end
    endtask

    task automatic test_miss();
        apply_reset();
        push_msg(0, "A?H", 1);
        wait_obs(3, 40);
        tests_run++;
        if (obs_str(0) != "T?A" || obs_str(3) != "010") begin
            tests_failed++; $display("FAIL miss_out got=%s/%s want=T?A/010", obs_str(0), obs_str(3));
        end
`ifdef DECODE_MISS_CNT_EN
        step(1'b1);
        tests_run++;
        if (miss_cnt !== 16'd1) begin
            tests_failed++; $display("FAIL miss_cnt got=%0d want=1", miss_cnt);
        end
`endif
    endtask

    task automatic test_hold();
        apply_reset();
        push_msg(0, "NIRRU", 1);
        wait_obs(2, 40);
        for (int k = 0; k < 3; k++) begin
            step(1'b0);
            tests_run++;
            if ({s_valid, s_char, s_rr[0]} !== {1'b1, 8'h4C, 1'b0}) begin
                tests_failed++;
                $display("FAIL hold_%0d got=v%b c%h rdy%b want=v1 c4c rdy0", k, s_valid, s_char, s_rr[0]);
            end
        end
        wait_obs(5, 40);
        tests_run++;
        if (obs_str(0) != "HELLO" || obs_str(1) != "00001") begin
            tests_failed++; $display("FAIL hold_stream got=%s/%s want=HELLO/00001", obs_str(0), obs_str(1));
        end
    endtask

    task automatic test_maxlen();
        string exp_ch = "";
        string exp_last = "";
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            exp_ch   = {exp_ch, "U"};
            exp_last = {exp_last, (i == 15) ? "1" : "0"};
        end
        push_msg(0, "EEEEEEEEEEEEEEEEEEEE", 0);
        wait_obs(20, 120);
        tests_run++;
        if (obs_str(0) != exp_ch) begin
            tests_failed++; $display("FAIL maxlen_chars got=%s want=%s", obs_str(0), exp_ch);
        end
        tests_run++;
        if (obs_str(1) != exp_last || obs_str(4) != exp_last) begin
            tests_failed++;
            $display("FAIL maxlen_last_err got=%s/%s want=%s", obs_str(1), obs_str(4), exp_last);
        end
        tests_run++;
        if (err_cnt !== 1) begin
            tests_failed++; $display("FAIL maxlen_err_pulses got=%0d want=1", err_cnt);
        end
        if (obs.size() == 20) begin
            tests_run++;
            if (obs[16].cyc - obs[15].cyc !== 2) begin
                tests_failed++; $display("FAIL maxlen_rearb_gap got=%0d want=2", obs[16].cyc - obs[15].cyc);
            end
        end
    endtask

    task automatic test_midreset();
        apply_reset();
        push_msg(0, "NIRRU", 1);
        wait_obs(2, 40);
        rst = 1'b1;
        step(1'b0);
        for (int r = 0; r < NREQ; r++) begin
            sq_ch[r].delete();
            sq_last[r].delete();
        end
        rst = 1'b0;
        obs.delete();
        step(1'b1);
        tests_run++;
        if ({s_valid, s_char, s_last, s_src, s_miss, s_busy, s_err, s_rr} !== 16'd0) begin
            tests_failed++;
            $display("FAIL midrst_clear got=%h want=0000", {s_valid, s_char, s_last, s_src, s_miss, s_busy, s_err, s_rr});
        end
        push_msg(0, "HA", 1);
        wait_obs(2, 40);
        tests_run++;
        if (obs_str(0) != "AT" || obs_str(1) != "01" || obs_str(2) != "00") begin
            tests_failed++;
            $display("FAIL midrst_fresh got=%s/%s/%s want=AT/01/00", obs_str(0), obs_str(1), obs_str(2));
        end
        tests_run++;
        if (err_cnt !== 0) begin
            tests_failed++; $display("FAIL midrst_err got=%0d want=0", err_cnt);
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_char  = '0;
        bus.req_last  = '0;
        bus.out_ready = 1'b0;
        cyc = 0; err_cnt = 0; tests_run = 0; tests_failed = 0;
        test_reset();
        test_hello();
        test_contention();
        test_miss();
        test_hold();
        test_maxlen();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
